ram_stream_reader: RTL and testbench
====================================

// Module: ram_stream_reader
// PURPOSE
//  Read-side engine for a simple dual-port RAM: sweeps a contiguous address window on the RAM read
//  port and emits each word on a valid/ready stream. RAM read latency is 1 clk (registered q), so
//  the block tracks one in-flight read and holds a 2-entry output buffer to tolerate stalls.
//  Sits between on-chip RAMs and stream consumers (DMA, display, UART TX).
// PARAMETERS
//  DATA_WIDTH  8  RAM word / stream data width
//  ADDR_WIDTH  6  RAM address width; window lengths 0..2**ADDR_WIDTH
// PORTS
//  clk        in   1             clock; all logic on posedge
//  rst        in   1             synchronous reset, active-high
//  start      in   1             start request; accepted only when busy==0
//  base_addr  in   ADDR_WIDTH    first address, sampled on accepted start
//  length     in   ADDR_WIDTH+1  word count, sampled on accepted start
//  busy       out  1             transfer in progress
//  done       out  1             1-cycle pulse at transfer end
//  read_addr  out  ADDR_WIDTH    to RAM read_addr
//  ram_q      in   DATA_WIDTH    from RAM q, valid the cycle after read_addr was presented
//  out_data   out  DATA_WIDTH    stream data
//  out_valid  out  1             stream valid
//  out_last   out  1             marks final word of transfer
//  out_ready  in   1             stream ready from consumer
// BEHAVIOUR
//  - Reset: busy=0, done=0, out_valid=0, out_last=0, out_data=0, read_addr=0; FSM IDLE, buffer empty,
//    in-flight flag clear. Reset mid-transfer aborts immediately: no done pulse, no further words.
//  - FSM IDLE -> RUN on start with length!=0 (busy=1 next cycle). RUN -> IDLE after handshake of
//    last word (out_valid&out_ready&out_last); done=1 and busy=0 the following cycle.
//  - start with length==0 in IDLE: no reads, no stream words; done pulses the next cycle, busy stays 0.
//  - start while busy=1 ignored. start in the cycle done is high is accepted (FSM already IDLE).
//  - Issue: cycle with RUN, issued<length and (buf_count + inflight - pop) < 2 is an issue cycle;
//    read_addr holds the issued address, RAM captures it that edge; ram_q written to buffer next edge.
//    read_addr increments after each issue, wraps mod 2**ADDR_WIDTH (base 62, len 4 -> 62,63,0,1).
//  - Latency: start sampled edge 0 -> first read issued cycle 1 -> first out_valid in cycle 3.
//  - Throughput: 1 word/clk with out_ready held high; no bubbles between words.
//  - Stream rules: once out_valid=1, out_data/out_last stay stable until handshake; out_valid never
//    drops without handshake. out_ready ignored when out_valid=0.
//  - Buffer: 2-entry FIFO; never overflows (issue credit above); out_ready low for any duration
//    stalls issue, in-flight word still lands. out_last=1 exactly on word number length.
//  - Counters ADDR_WIDTH+1 bits so length=2**ADDR_WIDTH reads every address exactly once.
// CONFIGURATION
//  RAM_READER_CHECKSUM_EN defined: extra port checksum out DATA_WIDTH = sum mod 2**DATA_WIDTH of all
//   handshaked words; cleared to 0 on accepted start and on rst; final and stable when done pulses,
//   held until next accepted start. Not defined: port and adder absent, other behaviour identical.
// TESTING  (bench RAM model: 1-clk registered read, preload mem[i]=i)
//  1 base=0,len=4,out_ready=1 -> out_data 0,1,2,3 on consecutive cycles, first valid 3 clks after
//    start, out_last on 3, done 1 clk after, checksum=6 (macro on).
//  2 base=62,len=4 -> read_addr 62,63,0,1; out 62,63,0,1; last on 1.
//  3 len=8, out_ready toggles 1/0 every cycle plus 5-clk low hold -> all 8 words in order, none
//    dropped/duplicated, out_data stable while stalled, read_addr issues stop while buffer full.
//  4 len=0 -> no out_valid, done pulse 1 clk after start, busy never 1; start during busy ignored.
//  5 len=64 -> 64 words 0..63 in order, out_last only on 63, checksum=0xE0 (2016 mod 256).
//  6 rst asserted after 2 words of len=10 -> next cycle out_valid=0, busy=0, no done; new start
//    base=5,len=2 works -> 5,6.

Source files
------------

// File: rtl/ram_stream_reader.sv
// Sweeps an address window on a 1-cycle-latency RAM read port and streams the words out with valid/ready.
// Optional running checksum of delivered words: define RAM_READER_CHECKSUM_EN.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready
`ifdef RAM_READER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH:0]   length_reg;
  logic [ADDR_WIDTH:0]   issued_reg;
  logic [ADDR_WIDTH-1:0] read_addr_reg;
  logic                  inflight_reg;
  logic                  inflight_last_reg;
  logic                  done_reg;
  logic [1:0]            count_reg;
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [DATA_WIDTH-1:0] buf_data_reg [2];
  logic                  buf_last_reg [2];

  logic       pop;
  logic       issue;
  logic       last_issue;
  logic [2:0] occ_next;

  // Occupancy after this edge if nothing new is issued; issuing only while it stays below 2
  // guarantees the word landing next cycle always finds a free slot.
  always_comb begin
    pop        = (count_reg != 2'd0) && out_ready;
    occ_next   = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    issue      = (state_reg == RUN) && (issued_reg < length_reg) && (occ_next < 3'd2);
    last_issue = (issued_reg == length_reg - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      length_reg        <= '0;
      issued_reg        <= '0;
      read_addr_reg     <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      done_reg          <= 1'b0;
      count_reg         <= 2'd0;
      wr_ptr_reg        <= 1'b0;
      rd_ptr_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              state_reg     <= RUN;
              length_reg    <= length;
              issued_reg    <= '0;
              read_addr_reg <= base_addr;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pop && buf_last_reg[rd_ptr_reg]) begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (issue) begin
        read_addr_reg <= read_addr_reg + 1'b1;
        issued_reg    <= issued_reg + 1'b1;
      end
      inflight_reg      <= issue;
      inflight_last_reg <= issue && last_issue;
      count_reg         <= occ_next[1:0];
      if (inflight_reg) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)          rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      always_ff @(posedge clk) begin
        if (rst) begin
          buf_data_reg[gi] <= '0;
          buf_last_reg[gi] <= 1'b0;
        end else if (inflight_reg && (wr_ptr_reg == 1'(gi))) begin
          buf_data_reg[gi] <= ram_q;
          buf_last_reg[gi] <= inflight_last_reg;
        end
      end
    end
  endgenerate

`ifdef RAM_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_reg <= '0;
    end else if (start && (state_reg == IDLE)) begin
      checksum_reg <= '0;
    end else if (pop) begin
      checksum_reg <= checksum_reg + out_data;
    end
  end

  assign checksum = checksum_reg;
`endif

  assign busy      = (state_reg == RUN);
  assign done      = done_reg;
  assign read_addr = read_addr_reg;
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = buf_data_reg[rd_ptr_reg];
  assign out_last  = buf_last_reg[rd_ptr_reg];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: directed transfers against a RAM model preloaded with mem[i]=i.
module tb_ram_stream_reader;

  localparam int DW = 8;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] ram_q = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready = 1'b0;
`ifdef RAM_READER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .read_addr (read_addr),
    .ram_q     (ram_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
`ifdef RAM_READER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
  always @(posedge clk) ram_q <= mem[read_addr];

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   hs_count = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int base, input int len);
    for (int i = 0; i < len; i++)
      sb.push_back('{d: DW'((base + i) % (1 << AW)), l: (i == len - 1)});
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(done === 1'b1, name, int'(done), 1);
  endtask

  task automatic monitor();
    bit            stall_pending;
    logic [DW-1:0] held_data;
    logic          held_last;
    exp_t          e;
    stall_pending = 1'b0;
    held_data     = '0;
    held_last     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_pending = 1'b0;
      end else begin
        if (stall_pending)
          chk(out_valid === 1'b1 && out_data === held_data && out_last === held_last,
              "stall_stable", int'({out_valid, out_last, out_data}), int'({1'b1, held_last, held_data}));
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          hs_count++;
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_word", int'(out_data), -1);
          end else begin
            e = sb.pop_front();
            $display("word data=%0d last=%0d (expected data=%0d last=%0d)", out_data, out_last, e.d, e.l);
            chk(out_data === e.d, "word_data", int'(out_data), int'(e.d));
            chk(out_last === e.l, "word_last", int'(out_last), int'(e.l));
          end
          stall_pending = 1'b0;
        end else if (out_valid === 1'b1) begin
          stall_pending = 1'b1;
          held_data     = out_data;
          held_last     = out_last;
        end else begin
          stall_pending = 1'b0;
        end
      end
    end
  endtask

  task automatic stimulus();
    logic [AW-1:0] ra_hold;
    int            hs0;
    int            n;
    ra_hold = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk(busy === 1'b0, "rst_busy", int'(busy), 0);
    chk(done === 1'b0, "rst_done", int'(done), 0);
    chk(out_valid === 1'b0, "rst_valid", int'(out_valid), 0);
    chk(out_last === 1'b0, "rst_last", int'(out_last), 0);
    chk(out_data === '0, "rst_data", int'(out_data), 0);
    chk(read_addr === '0, "rst_read_addr", int'(read_addr), 0);
    rst = 1'b0;

    // 1: base 0, len 4, latency and throughput
    out_ready = 1'b1;
    base_addr = 6'd0;
    length = 7'd4;
    push_words(0, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk(busy === 1'b1, "t1_busy", int'(busy), 1);
    tick();
    chk(out_valid === 1'b0, "t1_not_valid_yet", int'(out_valid), 0);
    tick();
    chk(out_valid === 1'b1, "t1_first_valid", int'(out_valid), 1);
    repeat (3) tick();
    chk(out_last === 1'b1, "t1_last", int'(out_last), 1);
    tick();
    chk(done === 1'b1, "t1_done", int'(done), 1);
    chk(busy === 1'b0, "t1_busy_low", int'(busy), 0);
`ifdef RAM_READER_CHECKSUM_EN
    chk(checksum === 8'd6, "t1_checksum", int'(checksum), 6);
`endif
    tick();
    chk(done === 1'b0, "t1_done_pulse", int'(done), 0);
    chk(sb.size() == 0, "t1_all_words", sb.size(), 0);

    // 2: address wrap 62,63,0,1
    base_addr = 6'd62;
    length = 7'd4;
    push_words(62, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk(read_addr === 6'd62, "t2_addr0", int'(read_addr), 62);
    tick();
    chk(read_addr === 6'd63, "t2_addr1", int'(read_addr), 63);
    tick();
    chk(read_addr === 6'd0, "t2_addr2", int'(read_addr), 0);
    tick();
    chk(read_addr === 6'd1, "t2_addr3", int'(read_addr), 1);
    wait_done(20, "t2_done");
    tick();
    chk(sb.size() == 0, "t2_all_words", sb.size(), 0);

    // 3: backpressure, toggling ready plus a 5-cycle low hold
    base_addr = 6'd10;
    length = 7'd8;
    push_words(10, 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      out_ready = (n >= 6 && n <= 10) ? 1'b0 : ((n % 2) == 0);
      tick();
      if (n == 7) ra_hold = read_addr;
      if (n == 10) begin
        chk(read_addr === ra_hold, "t3_issue_stalled", int'(read_addr), int'(ra_hold));
        chk(out_valid === 1'b1, "t3_valid_held", int'(out_valid), 1);
      end
      n++;
    end
    chk(done === 1'b1, "t3_done", int'(done), 1);
    chk(sb.size() == 0, "t3_all_words", sb.size(), 0);
    out_ready = 1'b1;

    // 4: zero length (issued in the cycle done is high), then start-while-busy ignored
    base_addr = 6'd30;
    length = 7'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk(done === 1'b1, "t4_len0_done", int'(done), 1);
    chk(busy === 1'b0, "t4_len0_busy", int'(busy), 0);
    chk(out_valid === 1'b0, "t4_len0_valid", int'(out_valid), 0);
    tick();
    chk(done === 1'b0, "t4_len0_done_pulse", int'(done), 0);
    chk(busy === 1'b0, "t4_len0_busy2", int'(busy), 0);
    base_addr = 6'd20;
    length = 7'd3;
    push_words(20, 3);
    start = 1'b1;
    tick();
    chk(busy === 1'b1, "t4_busy", int'(busy), 1);
    base_addr = 6'd40;
    length = 7'd5;
    repeat (2) tick();
    start = 1'b0;
    wait_done(20, "t4_done");

    // 5: full window, started in the done cycle
    base_addr = 6'd0;
    length = 7'd64;
    push_words(0, 64);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk(busy === 1'b1, "t5_start_in_done", int'(busy), 1);
    wait_done(200, "t5_done");
`ifdef RAM_READER_CHECKSUM_EN
    chk(checksum === 8'hE0, "t5_checksum", int'(checksum), 224);
`endif
    tick();
    chk(sb.size() == 0, "t5_all_words", sb.size(), 0);

    // 6: reset after two words, then a fresh transfer
    base_addr = 6'd0;
    length = 7'd10;
    push_words(0, 10);
    hs0 = hs_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (hs_count - hs0 < 2 && n < 50) begin
      tick();
      n++;
    end
    chk(hs_count - hs0 == 2, "t6_two_words", hs_count - hs0, 2);
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    sb.delete();
    chk(out_valid === 1'b0, "t6_valid_after_rst", int'(out_valid), 0);
    chk(busy === 1'b0, "t6_busy_after_rst", int'(busy), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk(done === 1'b0 && out_valid === 1'b0, "t6_quiet", int'({done, out_valid}), 0);
    end
    base_addr = 6'd5;
    length = 7'd2;
    push_words(5, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20, "t6_done");
    repeat (3) tick();
    chk(sb.size() == 0, "t6_all_words", sb.size(), 0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
